// File: rtl/debug_frame_dumper.sv
// -----------------------------------------------------------------------------
// debug_frame_dumper
//
// Purpose:
//   On a start request this block freezes the processor through cpu_hold. It
//   then streams one debug frame over a valid/ready byte interface:
//     HDR_BYTE, [status byte], fetchPC (MSB first), R0..R15 (each MSB first).
//   Register contents are read through the register file's debug port. Each
//   register costs one select cycle and one capture cycle, so the read data
//   has a full cycle to settle before it is latched.
//
// Optional feature:
//   `define DEBUG_DUMP_STATUS_EN adds a status byte right after the header:
//   {4'b0, StallF, StallD, FlushD, FlushE}, sampled on the edge that accepts
//   start. Without the macro the status state and register do not exist.
//
// Parameters:
//   WIDTH    - datapath word width, multiple of 8 (BPW = WIDTH/8 bytes/word)
//   HDR_BYTE - frame start marker
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   start         in   dump request (ignored while busy)
//   fetchPC       in   fetch-stage PC, latched when the frame starts
//   debug_reg_out in   register-file debug read data
//   StallF/StallD/FlushD/FlushE in  pipeline status (used by status byte)
//   debug_reg_sel out  register-file debug read select
//   cpu_hold      out  high while the processor must stay frozen
//   tx_data       out  frame byte
//   tx_valid      out  tx_data valid
//   tx_ready      in   sink accepts byte this cycle
//   busy          out  frame in progress
//   done          out  one-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module debug_frame_dumper #(
  parameter int          WIDTH    = 32,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] fetchPC,
  input  logic [WIDTH-1:0] debug_reg_out,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             FlushE,
  output logic [3:0]       debug_reg_sel,
  output logic             cpu_hold,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done
);

  localparam int BPW  = WIDTH / 8;
  localparam int CNTW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CNTW-1:0] LAST_BYTE = CNTW'(BPW - 1);

`ifdef DEBUG_DUMP_STATUS_EN
  typedef enum logic [2:0] {
    IDLE, HDR, STAT, PCB, SEL, CAP, REGB, FIN
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, HDR, PCB, SEL, CAP, REGB, FIN
  } state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [3:0]       r_index;
  logic [CNTW-1:0]  r_byteCnt;

`ifdef DEBUG_DUMP_STATUS_EN
  logic [7:0]       r_status;
`else
  // Pipeline status only feeds the optional status byte.
  logic             w_unusedStatus;
  assign w_unusedStatus = StallF ^ StallD ^ FlushD ^ FlushE;
`endif

  logic [WIDTH-1:0] w_shiftNext;
  logic             w_xfer;

  // Next byte is always the top byte of the shifted word, so the new tx_data
  // can be loaded on the same edge that accepts the current one.
  assign w_shiftNext = r_shift << 8;
  assign w_xfer      = tx_valid & tx_ready;

  // Single FSM with every output registered. tx_valid/tx_data change only on a
  // transfer edge or on entering a byte-emitting state, so they stay stable
  // across any number of stall cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_index       <= '0;
      r_byteCnt     <= '0;
`ifdef DEBUG_DUMP_STATUS_EN
      r_status      <= '0;
`endif
      debug_reg_sel <= '0;
      cpu_hold      <= 1'b0;
      tx_data       <= '0;
      tx_valid      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= HDR;
            r_shift   <= fetchPC;
            r_byteCnt <= '0;
`ifdef DEBUG_DUMP_STATUS_EN
            r_status  <= {4'b0000, StallF, StallD, FlushD, FlushE};
`endif
            cpu_hold  <= 1'b1;
            busy      <= 1'b1;
            tx_valid  <= 1'b1;
            tx_data   <= HDR_BYTE;
          end
        end

        HDR: begin
          if (w_xfer) begin
            r_byteCnt <= '0;
`ifdef DEBUG_DUMP_STATUS_EN
            r_state   <= STAT;
            tx_data   <= r_status;
`else
            r_state   <= PCB;
            tx_data   <= r_shift[WIDTH-1 -: 8];
`endif
          end
        end

`ifdef DEBUG_DUMP_STATUS_EN
        STAT: begin
          if (w_xfer) begin
            r_state <= PCB;
            tx_data <= r_shift[WIDTH-1 -: 8];
          end
        end
`endif

        PCB: begin
          if (w_xfer) begin
            r_shift <= w_shiftNext;
            if (r_byteCnt == LAST_BYTE) begin
              // Select R0 now; the read data settles during SEL.
              r_state       <= SEL;
              r_index       <= '0;
              debug_reg_sel <= '0;
              tx_valid      <= 1'b0;
            end else begin
              r_byteCnt <= r_byteCnt + 1'b1;
              tx_data   <= w_shiftNext[WIDTH-1 -: 8];
            end
          end
        end

        SEL: begin
          r_state <= CAP;
        end

        // Latch on the edge that ends CAP, one full cycle after the select.
        CAP: begin
          r_state   <= REGB;
          r_shift   <= debug_reg_out;
          r_byteCnt <= '0;
          tx_data   <= debug_reg_out[WIDTH-1 -: 8];
          tx_valid  <= 1'b1;
        end

        REGB: begin
          if (w_xfer) begin
            r_shift <= w_shiftNext;
            if (r_byteCnt == LAST_BYTE) begin
              tx_valid <= 1'b0;
              if (r_index == 4'd15) begin
                r_state <= FIN;
                done    <= 1'b1;
              end else begin
                r_state       <= SEL;
                r_index       <= r_index + 4'd1;
                debug_reg_sel <= r_index + 4'd1;
              end
            end else begin
              r_byteCnt <= r_byteCnt + 1'b1;
              tx_data   <= w_shiftNext[WIDTH-1 -: 8];
            end
          end
        end

        // cpu_hold and busy remain high through FIN and drop as we leave, so
        // start seen here is ignored and at least one IDLE cycle follows.
        FIN: begin
          r_state  <= IDLE;
          done     <= 1'b0;
          cpu_hold <= 1'b0;
          busy     <= 1'b0;
        end

        default: begin
          r_state  <= IDLE;
          done     <= 1'b0;
          cpu_hold <= 1'b0;
          busy     <= 1'b0;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_frame_dumper.sv
// -----------------------------------------------------------------------------
// tb_debug_frame_dumper
//
// Directed bench for debug_frame_dumper at WIDTH=32. A small register-file
// model answers debug reads with Rn = 0x1111_1111 * n. Expected frames are
// built from that model independently of the design.
// -----------------------------------------------------------------------------
module tb_debug_frame_dumper;

`ifdef DEBUG_DUMP_STATUS_EN
  localparam int FRAME_BYTES = 70;
  localparam int LATENCY     = 104;
`else
  localparam int FRAME_BYTES = 69;
  localparam int LATENCY     = 103;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] fetchPC;
  logic [31:0] debug_reg_out;
  logic        StallF, StallD, FlushD, FlushE;
  logic [3:0]  debug_reg_sel;
  logic        cpu_hold;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  logic        poison;

  int checks   = 0;
  int failures = 0;

  logic [7:0] capQ[$];
  logic [7:0] expQ[$];

  debug_frame_dumper #(.WIDTH(32), .HDR_BYTE(8'hA5)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .fetchPC       (fetchPC),
    .debug_reg_out (debug_reg_out),
    .StallF        (StallF),
    .StallD        (StallD),
    .FlushD        (FlushD),
    .FlushE        (FlushE),
    .debug_reg_sel (debug_reg_sel),
    .cpu_hold      (cpu_hold),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .done          (done)
  );

  // 100 MHz-style free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model; poison corrupts the read data for one cycle so a
  // capture on the wrong edge shows up in the transmitted bytes.
  always_comb begin
    debug_reg_out = (32'h1111_1111 * {28'd0, debug_reg_sel}) ^
                    (poison ? 32'hDEAD_BEEF : 32'h0);
  end

  // Expected frame: header, optional status 8'h09, PC bytes, R0..R15 bytes
  function automatic void build_expected(input logic [31:0] pc);
    logic [31:0] v;
    expQ.delete();
    expQ.push_back(8'hA5);
`ifdef DEBUG_DUMP_STATUS_EN
    expQ.push_back(8'h09);
`endif
    for (int b = 3; b >= 0; b--) expQ.push_back(pc[b*8 +: 8]);
    for (int n = 0; n < 16; n++) begin
      v = 32'h1111_1111 * n;
      for (int b = 3; b >= 0; b--) expQ.push_back(v[b*8 +: 8]);
    end
  endfunction

  // Index of the first differing byte, or -1 when capture equals expectation
  function automatic int first_diff();
    int lim;
    lim = (capQ.size() < expQ.size()) ? capQ.size() : expQ.size();
    for (int i = 0; i < lim; i++)
      if (capQ[i] !== expQ[i]) return i;
    if (capQ.size() != expQ.size()) return lim;
    return -1;
  endfunction

  // Drives one frame request and observes it until done (sampled on negedge).
  // Cycle 1 is the cycle in which start is first presented.
  task automatic collect_frame(input int readyPct, input bit holdStart,
                               input bit poisonSel, input logic [31:0] pc,
                               output int doneCycle, output int holdDrops,
                               output int unstable, output bit timedOut);
    int   cyc;
    int   gap;
    bit   prevValid, prevXfer;
    logic [7:0] prevData;
    capQ.delete();
    doneCycle = 0; holdDrops = 0; unstable = 0; timedOut = 1'b0;
    prevValid = 1'b0; prevXfer = 1'b0; prevData = '0; gap = 0;
    @(negedge clk);
    fetchPC = pc; StallF = 1'b1; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b1;
    start = 1'b1;
    tx_ready = 1'b1;
    cyc = 1;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (!holdStart) start = 1'b0;
      StallF = 1'b0; FlushE = 1'b0;
      if (done) begin
        doneCycle = cyc;
        break;
      end
      if (!cpu_hold) holdDrops++;
      if (prevValid && !prevXfer && (!tx_valid || tx_data !== prevData)) unstable++;
      if (busy && !tx_valid) gap++; else gap = 0;
      poison = poisonSel && (gap == 1);
      tx_ready = (readyPct >= 100) ? 1'b1 : ($urandom_range(0, 99) < readyPct);
      prevXfer  = tx_valid && tx_ready;
      prevValid = tx_valid;
      prevData  = tx_data;
      if (prevXfer) capQ.push_back(tx_data);
      if (cyc > 5000) begin
        timedOut = 1'b1;
        break;
      end
    end
    poison   = 1'b0;
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_valid got=%b want=0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_tx_data got=%h want=00", tx_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("[TB] FAIL reset_cpu_hold got=%b want=0", cpu_hold); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    checks++; if (debug_reg_sel !== 4'd0) begin failures++; $display("[TB] FAIL reset_sel got=%0d want=0", debug_reg_sel); end
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_after_release_busy got=%b want=0", busy); end
  endtask

  task automatic test_single_frame();
    int dc, hd, us, fd; bit to;
    build_expected(32'h0000_0040);
    collect_frame(100, 1'b0, 1'b0, 32'h0000_0040, dc, hd, us, to);
    checks++; if (to) begin failures++; $display("[TB] FAIL single_timeout got=timeout want=done"); end
    checks++; if (capQ.size() != FRAME_BYTES) begin failures++; $display("[TB] FAIL single_byte_count got=%0d want=%0d", capQ.size(), FRAME_BYTES); end
    fd = first_diff();
    checks++; if (fd != -1) begin failures++; $display("[TB] FAIL single_bytes first bad index=%0d", fd); end
    checks++; if (dc != LATENCY) begin failures++; $display("[TB] FAIL single_done_cycle got=%0d want=%0d", dc, LATENCY); end
    checks++; if (hd != 0) begin failures++; $display("[TB] FAIL single_cpu_hold_drops got=%0d want=0", hd); end
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("[TB] FAIL single_hold_in_fin got=%b want=1", cpu_hold); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL single_done_width got=%b want=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_after got=%b want=0", busy); end
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("[TB] FAIL single_hold_after got=%b want=0", cpu_hold); end
    checks++; if (debug_reg_sel !== 4'd15) begin failures++; $display("[TB] FAIL single_sel_hold got=%0d want=15", debug_reg_sel); end
  endtask

  task automatic test_random_ready();
    int dc, hd, us, fd; bit to;
    build_expected(32'hCAFE_0104);
    collect_frame(30, 1'b0, 1'b0, 32'hCAFE_0104, dc, hd, us, to);
    checks++; if (to) begin failures++; $display("[TB] FAIL random_timeout got=timeout want=done"); end
    fd = first_diff();
    checks++; if (fd != -1) begin failures++; $display("[TB] FAIL random_bytes first bad index=%0d got_count=%0d want_count=%0d", fd, capQ.size(), expQ.size()); end
    checks++; if (us != 0) begin failures++; $display("[TB] FAIL random_stability got=%0d unstable cycles want=0", us); end
    checks++; if (hd != 0) begin failures++; $display("[TB] FAIL random_cpu_hold_drops got=%0d want=0", hd); end
    checks++; if (dc <= LATENCY) begin failures++; $display("[TB] FAIL random_latency got=%0d want>%0d", dc, LATENCY); end
  endtask

  task automatic test_back_to_back();
    int dc, hd, us, fd, wait2; bit to;
    build_expected(32'h0000_0040);
    collect_frame(100, 1'b1, 1'b0, 32'h0000_0040, dc, hd, us, to);
    fd = first_diff();
    checks++; if (fd != -1) begin failures++; $display("[TB] FAIL b2b_bytes first bad index=%0d", fd); end
    checks++; if (dc != LATENCY) begin failures++; $display("[TB] FAIL b2b_done_cycle got=%0d want=%0d", dc, LATENCY); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle_gap got busy=%b valid=%b want 0 0", busy, tx_valid); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'hA5) begin failures++; $display("[TB] FAIL b2b_restart got busy=%b valid=%b data=%h want 1 1 a5", busy, tx_valid, tx_data); end
    start = 1'b0;
    wait2 = 0;
    while (!done && wait2 < 300) begin
      @(negedge clk);
      wait2++;
    end
    checks++; if (!done) begin failures++; $display("[TB] FAIL b2b_second_done got=timeout want=done"); end
  endtask

  task automatic test_reset_midframe();
    int n, dc, hd, us, fd; bit to;
    @(negedge clk);
    fetchPC = 32'h0000_0040;
    start = 1'b1;
    tx_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 200 && n < 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (tx_valid) n++;
    end
    @(negedge clk);
    checks++; if (n != 20) begin failures++; $display("[TB] FAIL midreset_reach got=%0d bytes want=20", n); end
    reset = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin failures++; $display("[TB] FAIL midreset_tx got valid=%b data=%h want 0 00", tx_valid, tx_data); end
    checks++; if (busy !== 1'b0 || cpu_hold !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL midreset_ctrl got busy=%b hold=%b done=%b want 0 0 0", busy, cpu_hold, done); end
    checks++; if (debug_reg_sel !== 4'd0) begin failures++; $display("[TB] FAIL midreset_sel got=%0d want=0", debug_reg_sel); end
    @(negedge clk);
    reset = 1'b1;
    build_expected(32'h1234_5678);
    collect_frame(100, 1'b0, 1'b0, 32'h1234_5678, dc, hd, us, to);
    fd = first_diff();
    checks++; if (fd != -1) begin failures++; $display("[TB] FAIL midreset_next_frame first bad index=%0d", fd); end
    checks++; if (dc != LATENCY) begin failures++; $display("[TB] FAIL midreset_done_cycle got=%0d want=%0d", dc, LATENCY); end
  endtask

  task automatic test_capture_timing();
    int dc, hd, us, fd; bit to;
    build_expected(32'h0BAD_F00D);
    collect_frame(100, 1'b0, 1'b1, 32'h0BAD_F00D, dc, hd, us, to);
    fd = first_diff();
    checks++; if (fd != -1) begin failures++; $display("[TB] FAIL capture_edge first bad index=%0d got=%h want=%h", fd, (fd >= 0 && fd < capQ.size()) ? capQ[fd] : 8'h00, (fd >= 0 && fd < expQ.size()) ? expQ[fd] : 8'h00); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; tx_ready = 1'b0; poison = 1'b0;
    fetchPC = '0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
    test_reset();
    test_single_frame();
    test_random_ready();
    test_back_to_back();
    test_reset_midframe();
    test_capture_timing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
